// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and sequencer state types shared by the ALU arbiter
package alu_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        SUB  = 2'b01,
        PAR  = 2'b10,
        COMP = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        WAKE,
        SEND_A,
        SEND_B,
        WAIT,
        RESP
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr, wrapping
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    logic [IDX_W-1:0] j;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        j       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any_req && req[j]) begin
                any_req  = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin sharing of one serial-protocol ALU among NUM_REQ requesters
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [2*NUM_REQ-1:0]          req_opcode,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_result,
    output logic                          resp_overflow,
    output logic                          resp_error,
    output logic                          alu_opcode_valid,
    output logic                          alu_opcode,
    output logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          alu_done,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_overflow,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT) + 1;

    arb_state_e            state_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      gnt_idx_q;
    logic [NUM_REQ-1:0]    gnt_oh_q;
    alu_op_e               op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  overflow_q;
    logic                  error_q;
    logic [WD_W-1:0]       wdog_q;
    logic                  alu_valid_q;
    logic                  alu_op_bit_q;
    logic [DATA_WIDTH-1:0] alu_data_q;
    logic [NUM_REQ-1:0]    resp_valid_q;
    logic                  busy_q;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [1:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic                  timeout_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .grant   (pick_gnt),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_op = req_opcode[2*i +: 2];
                sel_a  = req_a[DATA_WIDTH*i +: DATA_WIDTH];
                sel_b  = req_b[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // The ack is the only combinational output: it must land in the grant cycle itself,
    // and it is masked by reset so nothing leaks out while reset_n is low.
    assign req_ack     = (reset_n && state_q == IDLE && pick_any) ? pick_gnt : '0;
    assign timeout_hit = (wdog_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_idx_q    <= '0;
            gnt_oh_q     <= '0;
            op_q         <= ADD;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            error_q      <= 1'b0;
            wdog_q       <= '0;
            alu_valid_q  <= 1'b0;
            alu_op_bit_q <= 1'b0;
            alu_data_q   <= '0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        gnt_oh_q     <= pick_gnt;
                        gnt_idx_q    <= pick_idx;
                        op_q         <= alu_op_e'(sel_op);
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        alu_valid_q  <= 1'b1;
                        alu_op_bit_q <= 1'b0;
                        alu_data_q   <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= WAKE;
                    end
                end
                WAKE: begin
                    alu_op_bit_q <= op_q[0];
                    alu_data_q   <= a_q;
                    state_q      <= SEND_A;
                end
                SEND_A: begin
                    alu_op_bit_q <= op_q[1];
                    alu_data_q   <= b_q;
                    state_q      <= SEND_B;
                end
                SEND_B: begin
                    alu_valid_q  <= 1'b0;
                    alu_op_bit_q <= 1'b0;
                    alu_data_q   <= '0;
                    wdog_q       <= '0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    wdog_q <= wdog_q + WD_W'(1);
                    // done is checked first so a completion on the last watchdog cycle still counts
                    if (alu_done) begin
                        result_q     <= alu_result;
                        overflow_q   <= alu_overflow;
                        error_q      <= 1'b0;
                        resp_valid_q <= gnt_oh_q;
                        state_q      <= RESP;
                    end else if (timeout_hit) begin
                        result_q     <= '0;
                        overflow_q   <= 1'b0;
                        error_q      <= 1'b1;
                        resp_valid_q <= gnt_oh_q;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= '0;
                    busy_q       <= 1'b0;
                    ptr_q        <= (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_result      = result_q;
    assign resp_overflow    = overflow_q;
    assign resp_error       = error_q;
    assign alu_opcode_valid = alu_valid_q;
    assign alu_opcode       = alu_op_bit_q;
    assign alu_data         = alu_data_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - randomized bench with a pending-set arbitration model and a toy ALU
module tb_alu_rr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    req_valid;
    logic [2*NR-1:0]  req_opcode;
    logic [DW*NR-1:0] req_a;
    logic [DW*NR-1:0] req_b;
    logic [NR-1:0]    req_ack;
    logic [NR-1:0]    resp_valid;
    logic [DW-1:0]    resp_result;
    logic             resp_overflow;
    logic             resp_error;
    logic             alu_opcode_valid;
    logic             alu_opcode;
    logic [DW-1:0]    alu_data;
    logic             alu_done;
    logic [DW-1:0]    alu_result;
    logic             alu_overflow;
    logic             busy;

    int total = 0;
    int bad   = 0;

    bit          pv  [NR];
    logic [1:0]  pop [NR];
    logic [DW-1:0] pa [NR];
    logic [DW-1:0] pb [NR];
    int          ptr;

    always #5 clk = ~clk;

    alu_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .TIMEOUT    (TO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_opcode       (req_opcode),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_ack          (req_ack),
        .resp_valid       (resp_valid),
        .resp_result      (resp_result),
        .resp_overflow    (resp_overflow),
        .resp_error       (resp_error),
        .alu_opcode_valid (alu_opcode_valid),
        .alu_opcode       (alu_opcode),
        .alu_data         (alu_data),
        .alu_done         (alu_done),
        .alu_result       (alu_result),
        .alu_overflow     (alu_overflow),
        .busy             (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // toy ALU behaviour; the arbiter only forwards whatever it produces
    function automatic logic [DW:0] alu_fn(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            2'b00:   alu_fn = {1'b0, a} + {1'b0, b};
            2'b01:   alu_fn = {a < b, a - b};
            2'b10:   alu_fn = {{DW{1'b0}}, ^{a, b}};
            default: alu_fn = {1'b0, (a > b) ? DW'(1) : DW'(0)};
        endcase
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]            = pv[i];
            req_opcode[2*i +: 2]    = pop[i];
            req_a[DW*i +: DW]       = pa[i];
            req_b[DW*i +: DW]       = pb[i];
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        pv[i] = 1'b1; pop[i] = op; pa[i] = a; pb[i] = b;
        drive_reqs();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) pv[i] = 1'b0;
        drive_reqs();
    endtask

    function automatic int model_pick();
        for (int i = 0; i < NR; i++)
            if (pv[(ptr + i) % NR]) return (ptr + i) % NR;
        return -1;
    endfunction

    task automatic noise();
        alu_done     = 1'($urandom);
        alu_result   = DW'($urandom);
        alu_overflow = 1'($urandom);
    endtask

    // Entered at the negedge of an IDLE cycle; returns at the negedge of the following IDLE cycle.
    // d: WAIT cycle (0-based) in which the ALU pulses done, -1 for never.
    task automatic run_txn(input int d, input bit drop, input bit force_ff, input bit rnd);
        int            g;
        int            lat;
        bit            seen;
        bit            exp_err;
        logic [1:0]    eo;
        logic [DW-1:0] ea, eb, sa, sb;
        logic          sop0, sop1;
        logic [DW:0]   r, er;
        #1;
        g = model_pick();
        if (g < 0) begin
            set_req($urandom_range(0, NR-1), 2'($urandom), DW'($urandom), DW'($urandom));
            #1;
            g = model_pick();
        end
        eo = pop[g]; ea = pa[g]; eb = pb[g];
        alu_done = 1'b0;
        check_eq("ack", req_ack, 1 << g);
        check_eq("resp_pulse", resp_valid, 0);
        check_eq("busy_idle", busy, 0);
        @(negedge clk);
        if (drop) begin pv[g] = 1'b0; drive_reqs(); end
        check_eq("wake", {alu_opcode_valid, alu_opcode, alu_data}, {2'b10, DW'(0)});
        check_eq("ack_pulse", req_ack, 0);
        check_eq("busy", busy, 1);
        noise();
        @(negedge clk);
        sop0 = alu_opcode; sa = alu_data;
        check_eq("send_a", {alu_opcode_valid, alu_opcode, alu_data}, {1'b1, eo[0], ea});
        noise();
        @(negedge clk);
        sop1 = alu_opcode; sb = alu_data;
        check_eq("send_b", {alu_opcode_valid, alu_opcode, alu_data}, {1'b1, eo[1], eb});
        noise();
        r = force_ff ? {1'b1, {DW{1'b1}}} : alu_fn({sop1, sop0}, sa, sb);
        @(negedge clk);
        check_eq("wait_pins", {alu_opcode_valid, alu_opcode, alu_data}, 0);
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < TO + 4 && !seen; k++) begin
            alu_done     = (k == d);
            alu_result   = (k == d) ? r[DW-1:0] : DW'($urandom);
            alu_overflow = (k == d) ? r[DW] : 1'($urandom);
            @(negedge clk);
            alu_done = 1'b0;
            lat = k + 1;
            if (resp_valid != '0) seen = 1'b1;
        end
        check_eq("resp_seen", seen, 1);
        exp_err = !(d >= 0 && d < TO);
        er = force_ff ? {1'b1, {DW{1'b1}}} : alu_fn(eo, ea, eb);
        if (exp_err) er = '0;
        if (seen) begin
            check_eq("resp_lat", lat, exp_err ? TO : d + 1);
            check_eq("resp_valid", resp_valid, 1 << g);
            check_eq("resp_result", resp_result, er[DW-1:0]);
            check_eq("resp_ovf", resp_overflow, er[DW]);
            check_eq("resp_err", resp_error, exp_err);
            check_eq("busy_resp", busy, 1);
        end
        ptr = (g + 1) % NR;
        noise();
        if (rnd) begin
            for (int i = 0; i < NR; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 2'($urandom), DW'($urandom), DW'($urandom));
                else if (pv[i] && $urandom_range(0, 7) == 0)
                    pv[i] = 1'b0;
            end
            drive_reqs();
        end
        @(negedge clk);
    endtask

    // Entered at an IDLE negedge with a pending request; aborts it during SEND_A.
    task automatic reset_mid();
        int g;
        #1;
        g = model_pick();
        check_eq("rst_ack", req_ack, 1 << g);
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_in_send_a", alu_opcode_valid, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_outs", {req_ack, resp_valid, busy, alu_opcode_valid, alu_opcode, alu_data,
                              resp_result, resp_overflow, resp_error}, 0);
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_quiet", {resp_valid, busy, req_ack}, 0);
        end
        reset_n = 1'b1;
        ptr = 0;
    endtask

    function automatic int pick_d();
        int s;
        s = $urandom_range(0, 9);
        if (s < 7)  return $urandom_range(0, 5);
        if (s == 7) return -1;
        if (s == 8) return TO - 1;
        return TO - 2;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        alu_done     = 1'b0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        ptr          = 0;
        for (int i = 0; i < NR; i++) begin
            pv[i] = 1'b1; pop[i] = 2'($urandom); pa[i] = DW'($urandom); pb[i] = DW'($urandom);
        end
        drive_reqs();
        repeat (3) @(negedge clk);
        check_eq("reset_outs", {req_ack, resp_valid, busy, alu_opcode_valid, alu_opcode, alu_data,
                                resp_result, resp_overflow, resp_error}, 0);
        clear_reqs();
        reset_n = 1'b1;
        @(negedge clk);

        set_req(0, 2'b00, 8'h12, 8'h05);
        run_txn(1, 1'b1, 1'b0, 1'b0);
        check_eq("tp_result_hold", resp_result, 8'h17);

        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < NR; i++) set_req(i, 2'($urandom), DW'($urandom), DW'($urandom));
            for (int n = 0; n < NR; n++) run_txn($urandom_range(0, 4), 1'b1, 1'b0, 1'b0);
        end

        set_req(1, 2'b01, DW'($urandom), DW'($urandom));
        run_txn(0, 1'b1, 1'b0, 1'b0);
        set_req(1, 2'b10, DW'($urandom), DW'($urandom));
        set_req(3, 2'b11, DW'($urandom), DW'($urandom));
        run_txn(2, 1'b1, 1'b0, 1'b0);
        run_txn(2, 1'b1, 1'b0, 1'b0);

        set_req(2, 2'b00, DW'($urandom), DW'($urandom));
        run_txn(-1, 1'b1, 1'b0, 1'b0);
        set_req(0, 2'b01, DW'($urandom), DW'($urandom));
        run_txn(0, 1'b1, 1'b0, 1'b0);

        set_req(1, 2'b00, 8'h80, 8'h80);
        run_txn(TO - 1, 1'b1, 1'b1, 1'b0);

        for (int n = 0; n < 40; n++)
            run_txn(pick_d(), ($urandom_range(0, 3) != 0), 1'b0, 1'b1);

        clear_reqs();
        ptr = 0;
        set_req(1, 2'($urandom), DW'($urandom), DW'($urandom));
        run_txn(0, 1'b1, 1'b0, 1'b0);
        set_req(1, 2'($urandom), DW'($urandom), DW'($urandom));
        set_req(3, 2'($urandom), DW'($urandom), DW'($urandom));
        reset_mid();
        run_txn(1, 1'b1, 1'b0, 1'b0);
        run_txn(1, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one serial-protocol simple ALU among NUM_REQ requesters.
- Each requester presents a parallel operation (2-bit opcode, operands A and B); the block serialises it onto the ALU's opcode_valid/opcode/data pins.
- It waits for the ALU's done pulse and returns result/overflow to the granted requester.
- A watchdog converts a hung ALU into an error response.

Parameters:
DATA_WIDTH, 8, operand/result width; matches the ALU.
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT, 64, max cycles in WAIT before an error response is issued.

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request valid; held until req_ack
req_opcode  in  2*NUM_REQ  packed; 00 add, 01 sub, 10 parity, 11 compare
req_a  in  DATA_WIDTH*NUM_REQ  packed operand A
req_b  in  DATA_WIDTH*NUM_REQ  packed operand B
req_ack  out  NUM_REQ  one-hot 1-cycle pulse; operands captured
resp_valid  out  NUM_REQ  one-hot 1-cycle pulse; response fields valid
resp_result  out  DATA_WIDTH  result of the completed operation
resp_overflow  out  1  ALU overflow flag
resp_error  out  1  watchdog expired; result forced to 0
alu_opcode_valid  out  1  to ALU opcode_valid
alu_opcode  out  1  to ALU opcode (serial opcode bit)
alu_data  out  DATA_WIDTH  to ALU data
alu_done  in  1  from ALU done
alu_result  in  DATA_WIDTH  from ALU result
alu_overflow  in  1  from ALU overflow
busy  out  1  high in every state except IDLE

Behaviour:
Reset values:
- All outputs 0.
- State IDLE, round-robin pointer 0, watchdog 0.

States and transitions:
- IDLE: if any req_valid, grant the first set bit at or after the pointer, wrapping. In the same cycle: pulse req_ack[g], latch opcode/A/B into internal registers, go to WAKE.
- WAKE: alu_opcode_valid=1, alu_opcode=0, alu_data=0. Next state SEND_A.
- SEND_A: alu_opcode_valid=1, alu_opcode=op[0], alu_data=A. Next state SEND_B.
- SEND_B: alu_opcode_valid=1, alu_opcode=op[1], alu_data=B. Next state WAIT; watchdog cleared.
- WAIT: alu_opcode_valid=0, alu_data=0, watchdog increments each cycle.
  - alu_done=1: register alu_result/alu_overflow, error=0, go to RESP.
  - Watchdog reaches TIMEOUT-1 without done: result=0, overflow=0, error=1, go to RESP.
  - alu_done and timeout in the same cycle: done wins, error=0.
- RESP: one-cycle pulse on resp_valid[g] with the registered fields. Pointer <= (g+1) mod NUM_REQ. Return to IDLE.

Response fields:
- resp_result/overflow/error hold their value until the next RESP.
- They are only meaningful while resp_valid is high.

Latency and throughput:
- Minimum request-to-response latency, req_ack cycle to resp_valid cycle: 4 + ALU compute cycles.
- One operation in flight; new grants are taken only in IDLE.
- A requester that is still valid after resp_valid is re-arbitrated fairly.

Boundary conditions:
- req_valid dropped after ack: operation still completes and responds.
- req_valid dropped before ack: no effect.
- alu_done outside WAIT: ignored.
- Single active requester: served back-to-back, IDLE visited once between operations.
- Pointer wraps NUM_REQ-1 -> 0.
- reset_n low mid-operation: immediate return to reset values; no resp_valid is issued for the aborted operation.

Width rules:
- Watchdog is clog2(TIMEOUT)+1 bits.
- The grant index is clog2(NUM_REQ) bits.

Decomposition:
Package alu_pkg holds:
- opcode typedef (enum ADD/SUB/PAR/COMP, 2 bits)
- arbiter state enum (IDLE, WAKE, SEND_A, SEND_B, WAIT, RESP)

Sub-module rr_pick: combinational round-robin priority pick, inputs req vector and pointer, outputs one-hot grant, index and any_req. The FSM, latch registers and watchdog stay in alu_rr_arbiter.

Test Plan:
- Single request: req0, opcode 00, A=8'h12, B=8'h05, ALU model done after 2 cycles → alu pins carry (1,0,00),(1,0,12),(1,0,05); resp_valid=0001, result 8'h17, overflow 0, error 0.
- All four request simultaneously after reset → grants in order 0,1,2,3. Re-asserting all → next round starts at 0; each resp_valid matches its ack.
- Pointer at 2, only req1 and req3 valid → req3 granted first, then req1 (wrap).
- ALU model never asserts done, TIMEOUT=64 → resp_valid 64 cycles after entering WAIT with error=1 and result 0. Arbiter then returns to IDLE and serves the next request normally.
- alu_done coincides with the final watchdog cycle, ALU result 8'hFF, overflow 1 → error=0, result 8'hFF, overflow 1.
- reset_n pulsed low during SEND_A → all outputs 0 asynchronously, no resp_valid. Requester still valid after release → re-granted from pointer 0.
